// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity-protected frame receiver.
package parity_frame_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Bit counter width able to hold 0..data_w.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR cell used for the running parity accumulator.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/parity_frame_rx.sv
// Frame receiver: start bit, LSB-first data, parity bit, stop bit, delivered
// through a one-entry valid/ready buffer with parity/frame error flags.
module parity_frame_rx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = cnt_width(DATA_W);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [DATA_W-1:0]   shreg_r, shreg_s;
    logic [DATA_W:0]     shift_s;
    logic                acc_r, acc_s, xor_s;
    logic                perr_pend_r, perr_pend_s;
    logic                done_s, ferr_new_s, free_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                valid_r, valid_s;
    logic                perr_r, perr_s;
    logic                ferr_r, ferr_s;
    logic                ovr_r, ovr_s;

    xor_gate u_parity_xor (
        .a (acc_r),
        .b (rx_bit),
        .y (xor_s)
    );

    // Incoming bit lands at the MSB end so LSB-first data ends up in order.
    assign shift_s = {rx_bit, shreg_r};

    // State, datapath and output buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shreg_r     <= {DATA_W{1'b0}};
            acc_r       <= 1'b0;
            perr_pend_r <= 1'b0;
            data_r      <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            perr_r      <= 1'b0;
            ferr_r      <= 1'b0;
            ovr_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shreg_r     <= shreg_s;
            acc_r       <= acc_s;
            perr_pend_r <= perr_pend_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            perr_r      <= perr_s;
            ferr_r      <= ferr_s;
            ovr_r       <= ovr_s;
        end
    end

    // Frame FSM: advances only on bit_en strobes.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shreg_s     = shreg_r;
        acc_s       = acc_r;
        perr_pend_s = perr_pend_r;
        done_s      = 1'b0;
        ferr_new_s  = 1'b0;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (rx_bit != LINE_IDLE) begin
                        state_s = DATA;
                        cnt_s   = {CNT_W{1'b0}};
                        acc_s   = ODD_PARITY;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shreg_s = shift_s[DATA_W:1];
                    acc_s   = xor_s;
                    cnt_s   = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    acc_s       = xor_s;
                    perr_pend_s = xor_s;
                    state_s     = STOP;
                end
                STOP: begin
                    done_s = 1'b1;
                    if (rx_bit == LINE_IDLE) begin
                        state_s = IDLE;
                    end else begin
                        ferr_new_s = 1'b1;
                        state_s    = WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_bit == LINE_IDLE) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_IDLE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // One-entry output buffer; a load in the accept cycle is back-to-back.
    always_comb begin
        free_s  = !valid_r || rx_ready;
        data_s  = data_r;
        valid_s = valid_r;
        perr_s  = perr_r;
        ferr_s  = ferr_r;
        ovr_s   = 1'b0;
        if (done_s && free_s) begin
            data_s  = shreg_r;
            valid_s = 1'b1;
            perr_s  = perr_pend_r;
            ferr_s  = ferr_new_s;
        end else if (done_s) begin
            ovr_s = 1'b1;
        end else if (valid_r && rx_ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end
    end

    assign rx_data    = data_r;
    assign rx_valid   = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign overrun    = ovr_r;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even- and odd-parity instances share stimulus and
// are checked every cycle against a frame-level reference model.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n, bit_en, rx_bit, rx_ready;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1;
    logic       parity_err0, parity_err1;
    logic       frame_err0, frame_err1;
    logic       overrun0, overrun1;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_perr0 = 1'b0;
    logic       m_perr1 = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ovr   = 1'b0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready),
        .parity_err(parity_err0), .frame_err(frame_err0), .overrun(overrun0)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_bit(rx_bit),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready),
        .parity_err(parity_err1), .frame_err(frame_err1), .overrun(overrun1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, let the model consume the edge, then compare.
    // done marks the stop-bit sample of frame (d, pbit, sbit).
    task automatic step(input logic rst, input logic en, input logic b, input logic done,
                        input logic [7:0] d, input logic pbit, input logic sbit);
        logic rdy;
        logic free;
        rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        rst_n = rst; bit_en = en; rx_bit = b; rx_ready = rdy;
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_perr0 = 1'b0; m_perr1 = 1'b0;
            m_ferr = 1'b0; m_ovr = 1'b0;
        end else begin
            free  = !m_valid || rdy;
            m_ovr = 1'b0;
            if (done && free) begin
                m_valid = 1'b1;
                m_data  = d;
                m_perr0 = (^d) ^ pbit;
                m_perr1 = ~m_perr0;
                m_ferr  = ~sbit;
            end else if (done) begin
                m_ovr = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("valid_even", 32'(rx_valid0), 32'(m_valid));
        chk("valid_odd", 32'(rx_valid1), 32'(m_valid));
        chk("overrun_even", 32'(overrun0), 32'(m_ovr));
        chk("overrun_odd", 32'(overrun1), 32'(m_ovr));
        if (m_valid || !rst) begin
            chk("data_even", 32'(rx_data0), 32'(m_data));
            chk("data_odd", 32'(rx_data1), 32'(m_data));
            chk("perr_even", 32'(parity_err0), 32'(m_perr0));
            chk("perr_odd", 32'(parity_err1), 32'(m_perr1));
            chk("ferr_even", 32'(frame_err0), 32'(m_ferr));
            chk("ferr_odd", 32'(frame_err1), 32'(m_ferr));
        end
    endtask

    task automatic line(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, b, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Full frame; gap idle-strobe cycles (random line value) precede each bit.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int gap);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int g = 0; g < gap; g++) step(1'b1, 1'b0, 1'($urandom), 1'b0, d, pbit, sbit);
            step(1'b1, 1'b1, bits[i], (i == 10), d, pbit, sbit);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       pb, sb;
        int         gap;

        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        ready_mode = 1;
        line(2, 1'b1);
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        chk("a5_data", 32'(rx_data0), 32'h000000A5);
        line(2, 1'b1);

        send_frame(8'h01, 1'b0, 1'b1, 0);
        chk("x01_perr_even", 32'(parity_err0), 32'd1);
        chk("x01_perr_odd", 32'(parity_err1), 32'd0);
        line(1, 1'b1);

        send_frame(8'h3C, 1'b0, 1'b0, 0);
        chk("x3c_ferr", 32'(frame_err0), 32'd1);
        line(3, 1'b0);
        line(1, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        chk("x5a_data", 32'(rx_data0), 32'h0000005A);
        line(2, 1'b1);

        ready_mode = 0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        line(1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        line(2, 1'b1);
        chk("overrun_keep", 32'(rx_data0), 32'h00000011);
        ready_mode = 1;
        line(3, 1'b1);

        send_frame(8'hC3, 1'b0, 1'b1, 3);
        line(2, 1'b1);

        send_frame(8'hF0, 1'b1, 1'b1, 0);
        ready_mode = 0;
        line(1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        line(4, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        ready_mode = 1;
        line(2, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1, 0);
        line(2, 1'b1);

        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            d   = 8'($urandom);
            pb  = (^d) ^ ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 4) != 0);
            gap = $urandom_range(0, 2);
            send_frame(d, pb, sb, gap);
            if (!sb) line($urandom_range(0, 2), 1'b0);
            line($urandom_range(1, 3), 1'b1);
        end

        ready_mode = 1;
        line(3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
